// File: rtl/alu16_seq_pkg.sv
// ============================================================================
// Module   : alu16_pkg
// Brief    : Shared widths and FSM state type for the nibble-serial 74181 ALU.
// Revision : 1.0
// ============================================================================
`default_nettype none

package alu16_pkg;

   localparam int WIDTH   = 16;
   localparam int NIBBLES = 4;
   localparam int NIB_W   = 4;
   localparam int IDX_W   = 2;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

`default_nettype wire

// File: rtl/alu16_seq_if.sv
// ============================================================================
// Module   : alu16_seq_if
// Brief    : Request/response bundle for alu16_seq (valid/ready on both sides).
// Revision : 1.0
// ============================================================================
`default_nettype none

interface alu16_seq_if;
   import alu16_pkg::*;

   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [3:0]       s;
   logic             m;
   logic             cin_n;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] f;
   logic             cout_n;
   logic             aeq_b;
   logic             zero;

   modport master (
      output in_valid, a, b, s, m, cin_n, out_ready,
      input  in_ready, out_valid, f, cout_n, aeq_b, zero
   );

   modport slave (
      input  in_valid, a, b, s, m, cin_n, out_ready,
      output in_ready, out_valid, f, cout_n, aeq_b, zero
   );

endinterface

`default_nettype wire

// File: rtl/alu_74181.sv
// ============================================================================
// Module   : alu_74181
// Brief    : 4-bit 74181 ALU slice, active-high data, active-low carries.
// Revision : 1.0
// ============================================================================
`default_nettype none

module alu_74181 (
   input  wire logic [3:0] a,
   input  wire logic [3:0] b,
   input  wire logic [3:0] s,
   input  wire logic       m,
   input  wire logic       cn_n,
   output logic      [3:0] f,
   output logic            cn4_n,
   output logic            aeq_b
);

   logic [3:0] w_x;
   logic [3:0] w_y;
   logic       w_nc;

   // w_x/w_y are the inverted propagate/generate terms of the original part
   assign w_x = ~(a | (b & {4{s[0]}}) | (~b & {4{s[1]}}));
   assign w_y = ~((a & ~b & {4{s[2]}}) | (a & b & {4{s[3]}}));

   always_comb begin
      f    = '0;
      w_nc = cn_n;
      for (int i = 0; i < 4; i++) begin
         f[i] = ~(w_x[i] ^ w_y[i]) ^ (~m & w_nc);
         w_nc = w_y[i] & (w_x[i] | w_nc);
      end
      cn4_n = w_nc;
   end

   assign aeq_b = &f;

endmodule

`default_nettype wire

// File: rtl/alu16_seq.sv
// ============================================================================
// Module   : alu16_seq
// Brief    : 16-bit 74181 operation computed over four cycles on one 4-bit slice.
// Revision : 1.0
// ============================================================================
`default_nettype none

module alu16_seq
   import alu16_pkg::*;
(
   input  wire logic  clk,
   input  wire logic  rst,
   alu16_seq_if.slave bus
);

   state_t           r_state;
   logic [IDX_W-1:0] r_idx;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [3:0]       r_s;
   logic             r_m;
   logic             r_cin_n;
   logic [WIDTH-1:0] r_f;
   logic             r_cout_n;
   logic             r_aeq;
   logic             r_out_valid;
   logic             r_in_ready;

   logic [NIB_W-1:0] w_a_nib;
   logic [NIB_W-1:0] w_b_nib;
   logic [NIB_W-1:0] w_f_nib;
   logic             w_cn_n;
   logic             w_cn4_n;
   logic             w_e;

   assign w_a_nib = r_a[{r_idx, 2'b00} +: NIB_W];
   assign w_b_nib = r_b[{r_idx, 2'b00} +: NIB_W];
   // Nibble 0 takes the captured carry; later nibbles take the previous Cn4.
   assign w_cn_n  = (r_idx == '0) ? r_cin_n : r_cout_n;

   alu_74181 u_alu (
      .a     (w_a_nib),
      .b     (w_b_nib),
      .s     (r_s),
      .m     (r_m),
      .cn_n  (w_cn_n),
      .f     (w_f_nib),
      .cn4_n (w_cn4_n),
      .aeq_b (w_e)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= IDLE;
         r_idx       <= '0;
         r_a         <= '0;
         r_b         <= '0;
         r_s         <= '0;
         r_m         <= 1'b0;
         r_cin_n     <= 1'b1;
         r_f         <= '0;
         r_cout_n    <= 1'b1;
         r_aeq       <= 1'b0;
         r_out_valid <= 1'b0;
         r_in_ready  <= 1'b1;
      end else begin
         case (r_state)
            IDLE: begin
               if (bus.in_valid) begin
                  r_a        <= bus.a;
                  r_b        <= bus.b;
                  r_s        <= bus.s;
                  r_m        <= bus.m;
                  r_cin_n    <= bus.cin_n;
                  r_idx      <= '0;
                  r_aeq      <= 1'b1;
                  r_in_ready <= 1'b0;
                  r_state    <= RUN;
               end
            end
            RUN: begin
               r_f[{r_idx, 2'b00} +: NIB_W] <= w_f_nib;
               r_cout_n <= w_cn4_n;
               r_aeq    <= r_aeq & w_e;
               r_idx    <= r_idx + 1'b1;
               if (r_idx == IDX_W'(NIBBLES - 1)) begin
                  r_out_valid <= 1'b1;
                  r_state     <= DONE;
               end
            end
            DONE: begin
               if (bus.out_ready) begin
                  r_out_valid <= 1'b0;
                  r_in_ready  <= 1'b1;
                  r_state     <= IDLE;
               end
            end
            default: begin
               r_out_valid <= 1'b0;
               r_in_ready  <= 1'b1;
               r_state     <= IDLE;
            end
         endcase
      end
   end

   assign bus.in_ready  = r_in_ready;
   assign bus.out_valid = r_out_valid;
   assign bus.f         = r_f;
   assign bus.cout_n    = r_cout_n;
   assign bus.aeq_b     = r_aeq;
   assign bus.zero      = (r_f == '0);

endmodule

`default_nettype wire

// File: tb/tb_alu16_seq.sv
// ============================================================================
// Module   : tb_alu16_seq
// Brief    : Randomised and directed checks of alu16_seq against a 74181 table model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_alu16_seq;
   import alu16_pkg::*;

   logic clk = 1'b0;
   logic rst;
   int   n_vec = 0;
   int   n_err = 0;

   alu16_seq_if bus ();

   alu16_seq u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // 74181 datasheet function table: {cout_n, f}
   function automatic logic [16:0] ref_alu(input logic [15:0] a, input logic [15:0] b,
                                            input logic [3:0] s, input logic m, input logic cin_n);
      logic [15:0] t1, t2, fl;
      logic [16:0] sum;
      case (s)
         4'h0: begin t1 = a;        t2 = 16'h0;    fl = ~a;       end
         4'h1: begin t1 = a | b;    t2 = 16'h0;    fl = ~(a | b); end
         4'h2: begin t1 = a | ~b;   t2 = 16'h0;    fl = ~a & b;   end
         4'h3: begin t1 = 16'hFFFF; t2 = 16'h0;    fl = 16'h0;    end
         4'h4: begin t1 = a;        t2 = a & ~b;   fl = ~(a & b); end
         4'h5: begin t1 = a | b;    t2 = a & ~b;   fl = ~b;       end
         4'h6: begin t1 = a;        t2 = ~b;       fl = a ^ b;    end
         4'h7: begin t1 = a & ~b;   t2 = 16'hFFFF; fl = a & ~b;   end
         4'h8: begin t1 = a;        t2 = a & b;    fl = ~a | b;   end
         4'h9: begin t1 = a;        t2 = b;        fl = ~(a ^ b); end
         4'hA: begin t1 = a | ~b;   t2 = a & b;    fl = b;        end
         4'hB: begin t1 = a & b;    t2 = 16'hFFFF; fl = a & b;    end
         4'hC: begin t1 = a;        t2 = a;        fl = 16'hFFFF; end
         4'hD: begin t1 = a | b;    t2 = a;        fl = a | ~b;   end
         4'hE: begin t1 = a | ~b;   t2 = a;        fl = a | b;    end
         default: begin t1 = a;     t2 = 16'hFFFF; fl = a;        end
      endcase
      sum = {1'b0, t1} + {1'b0, t2} + {16'h0, ~cin_n};
      return {~sum[16], m ? fl : sum[15:0]};
   endfunction

   task automatic scramble();
      bus.in_valid = 1'($urandom_range(0, 1));
      bus.a        = 16'($urandom);
      bus.b        = 16'($urandom);
      bus.s        = 4'($urandom_range(0, 15));
      bus.m        = 1'($urandom_range(0, 1));
      bus.cin_n    = 1'($urandom_range(0, 1));
   endtask

   task automatic run_op(input logic [15:0] ta, input logic [15:0] tb, input logic [3:0] ts,
                         input logic tm, input logic tcin, input int hold);
      logic [16:0] exp;
      logic        exp_aeq;
      logic        exp_zero;
      int          lat;
      exp      = ref_alu(ta, tb, ts, tm, tcin);
      exp_aeq  = (exp[15:0] == 16'hFFFF);
      exp_zero = (exp[15:0] == 16'h0000);
      @(negedge clk);
      check_eq("in_ready_idle", 32'(bus.in_ready), 32'd1);
      bus.a = ta; bus.b = tb; bus.s = ts; bus.m = tm; bus.cin_n = tcin;
      bus.in_valid  = 1'b1;
      bus.out_ready = 1'b0;
      @(negedge clk);
      lat = 0;
      scramble();
      check_eq("in_ready_run", 32'(bus.in_ready), 32'd0);
      while (bus.out_valid !== 1'b1 && lat < 12) begin
         @(negedge clk);
         lat++;
         scramble();
      end
      check_eq("latency", 32'(lat), 32'd4);
      check_eq("f", 32'(bus.f), 32'(exp[15:0]));
      check_eq("flags", 32'({bus.cout_n, bus.aeq_b, bus.zero}),
               32'({exp[16], exp_aeq, exp_zero}));
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         scramble();
         check_eq("hold", 32'({bus.out_valid, bus.in_ready, bus.cout_n, bus.aeq_b, bus.f}),
                  32'({1'b1, 1'b0, exp[16], exp_aeq, exp[15:0]}));
      end
      // in_valid stays high across the release edge; it must not be taken
      bus.out_ready = 1'b1;
      bus.in_valid  = 1'b1;
      @(negedge clk);
      check_eq("release", 32'({bus.out_valid, bus.in_ready, bus.f}),
               32'({1'b0, 1'b1, exp[15:0]}));
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b0;
   endtask

   initial begin
      rst           = 1'b1;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      bus.a = '0; bus.b = '0; bus.s = '0; bus.m = 1'b0; bus.cin_n = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check_eq("reset_state",
               32'({bus.in_ready, bus.out_valid, bus.cout_n, bus.aeq_b, bus.zero, bus.f}),
               32'({1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0000}));

      run_op(16'h1234, 16'h1111, 4'b1001, 1'b0, 1'b1, 0);
      run_op(16'hFFFF, 16'h0001, 4'b1001, 1'b0, 1'b1, 1);
      run_op(16'h5000, 16'h1000, 4'b0110, 1'b0, 1'b0, 0);
      run_op(16'h3C3C, 16'h3C3C, 4'b0110, 1'b0, 1'b1, 0);
      run_op(16'hF0F0, 16'hFF00, 4'b0110, 1'b1, 1'b1, 0);
      run_op(16'hA5A5, 16'h0F0F, 4'b1001, 1'b0, 1'b0, 10);

      // asynchronous reset after two nibbles have been written
      @(negedge clk);
      bus.a = 16'h1234; bus.b = 16'h1111; bus.s = 4'b1001; bus.m = 1'b0; bus.cin_n = 1'b1;
      bus.in_valid = 1'b1;
      @(negedge clk);
      bus.in_valid = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #2 rst = 1'b1;
      #1 check_eq("rst_mid_run", 32'({bus.in_ready, bus.out_valid, bus.cout_n, bus.aeq_b, bus.f}),
                  32'({1'b1, 1'b0, 1'b1, 1'b0, 16'h0000}));
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         check_eq("rst_no_valid", 32'(bus.out_valid), 32'd0);
      end
      run_op(16'h1234, 16'h1111, 4'b1001, 1'b0, 1'b1, 0);

      for (int n = 0; n < 40; n++) begin
         run_op(16'($urandom), 16'($urandom), 4'($urandom_range(0, 15)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, 3));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/alu16_seq.md
ALU16_SEQ -- requirements
Module: alu16_seq

Interface
REQ-001 clk  in  1  single clock; all state updates on rising edge.
REQ-002 rst  in  1  asynchronous, active-high reset.
REQ-003 in_valid  in  1  operation request valid.
REQ-004 in_ready  out  1  block can accept a request; high only in IDLE.
REQ-005 a  in  16  operand A.
REQ-006 b  in  16  operand B.
REQ-007 s  in  4  74181 function select, applied to every nibble.
REQ-008 m  in  1  mode: 1 = logic, 0 = arithmetic.
REQ-009 cin_n  in  1  carry into nibble 0, 74181 active-high-data convention (1 = no carry).
REQ-010 out_valid  out  1  result valid; held until accepted.
REQ-011 out_ready  in  1  downstream accepts result.
REQ-012 f  out  16  result word.
REQ-013 cout_n  out  1  Cn4 of nibble 3 (0 = carry out).
REQ-014 aeq_b  out  1  AND of the E output of all four nibbles.
REQ-015 zero  out  1  f == 16'h0000.

Function
REQ-016 The block SHALL compute one 16-bit 74181 operation per request by time-multiplexing a single 4-bit alu_74181 over nibbles 0..3, LSB first.
REQ-017 On accept (in_valid & in_ready at a rising edge), the block SHALL capture a, b, s, m, cin_n into internal registers; later input changes SHALL NOT affect the operation.
REQ-018 States SHALL be IDLE, RUN, DONE. Transitions: IDLE->RUN on accept; RUN->DONE after the edge that writes nibble 3; DONE->IDLE when out_ready is high.
REQ-019 In RUN, a 2-bit nibble index SHALL select a[4k+3:4k] and b[4k+3:4k]; each edge SHALL write F into f[4k+3:4k], latch Cn4 into the carry register, AND E into the equality accumulator, and increment the index.
REQ-020 Cn for nibble 0 SHALL be the captured cin_n; Cn for nibble k>0 SHALL be the Cn4 latched from nibble k-1, polarity unchanged.
REQ-021 Latency: out_valid SHALL rise exactly 4 cycles after the accept edge.
REQ-022 In logic mode (m=1), carry chaining SHALL proceed unchanged; cout_n SHALL report the latched Cn4 of nibble 3.
REQ-023 In DONE, f, cout_n, aeq_b, zero SHALL hold stable while out_valid=1 and out_ready=0.
REQ-024 in_ready SHALL be 0 in RUN and DONE; in_valid there SHALL be ignored. No back-to-back accept in the DONE->IDLE cycle.
REQ-025 Nibble index SHALL reset to 0 on entry to RUN; the equality accumulator SHALL preset to 1 on accept.
REQ-026 Outside DONE, out_valid SHALL be 0; f, cout_n, aeq_b hold their last values.

Reset
REQ-027 rst SHALL asynchronously force state IDLE, nibble index 0, f=16'h0000, cout_n=1, aeq_b=0, out_valid=0, in_ready=1 after release.
REQ-028 rst asserted during RUN or DONE SHALL discard the operation; no out_valid pulse SHALL follow.

Structure
REQ-029 Package alu16_pkg SHALL hold WIDTH=16, NIBBLES=4, and the state enum (IDLE, RUN, DONE).
REQ-030 The datapath SHALL instantiate exactly one existing alu_74181 as its sole sub-module; FSM and registers live in alu16_seq.

Verification
REQ-031 Add: m=0 s=1001 cin_n=1 a=16'h1234 b=16'h1111 -> f=16'h2345, cout_n=1, zero=0, out_valid 4 cycles after accept.
REQ-032 Carry ripple: m=0 s=1001 cin_n=1 a=16'hFFFF b=16'h0001 -> f=16'h0000, cout_n=0, zero=1.
REQ-033 Subtract/equal: m=0 s=0110 cin_n=0 a=16'h5000 b=16'h1000 -> f=16'h4000, cout_n=0; then cin_n=1 a=b=16'h3C3C -> f=16'hFFFF, aeq_b=1.
REQ-034 Logic XOR: m=1 s=0110 a=16'hF0F0 b=16'hFF00 -> f=16'h0FF0; operands toggled after accept -> result unchanged.
REQ-035 Backpressure: out_ready=0 for 10 cycles in DONE -> f, cout_n stable, in_ready=0, new in_valid ignored; out_ready=1 -> IDLE next edge.
REQ-036 Reset mid-RUN after 2 nibbles -> immediate IDLE, f=16'h0000, out_valid never asserts; next request completes normally.
